// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - shared state, opcode and select encodings for the multicycle control
package mips_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control-to-datapath bundle: decode inputs, memory handshake, selects
interface mips_multicycle_ctrl_if #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
);
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            zero;
    logic            mem_ready;
    logic            mem_req;
    logic            mem_write;
    logic            iord;
    logic            ir_write;
    logic            pc_en;
    logic [1:0]      pc_src;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [3:0]      alu_control;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            instr_done;
    logic            illegal_op;
    logic [ST_W-1:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
               alu_op, alu_control, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op,
               state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
               alu_op, alu_control, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op,
               state_dbg
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// rtl/mips_multicycle_ctrl_alu_dec.sv - AluDecoder: alu_op plus funct to 4-bit ALU control
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [1:0]      i_alu_op,
    input  logic [OP_W-1:0] i_funct,
    output logic [3:0]      o_alu_control
);
    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control = ALUC_ADD;
            ALUOP_SUB:   o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                // unknown funct codes fall back to add so the ALU never sees an undefined op
                case (i_funct)
                    FN_ADD:  o_alu_control = ALUC_ADD;
                    FN_SUB:  o_alu_control = ALUC_SUB;
                    FN_AND:  o_alu_control = ALUC_AND;
                    FN_OR:   o_alu_control = ALUC_OR;
                    FN_SLT:  o_alu_control = ALUC_SLT;
                    default: o_alu_control = ALUC_ADD;
                endcase
            end
            default:     o_alu_control = ALUC_ADD;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore main control FSM for the multicycle MIPS datapath
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    mips_multicycle_ctrl_if.master  bus
);
    state_t     r_state;
    state_t     w_next;
    logic       w_mem_req, w_mem_write, w_iord, w_ir_write, w_pc_write, w_branch;
    logic [1:0] w_pc_src, w_alu_src_b, w_alu_op;
    logic       w_alu_src_a, w_reg_dst, w_mem_to_reg, w_reg_write, w_instr_done, w_illegal_op;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_FETCH;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_pc_src     = PCSRC_ALU;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_B;
        w_alu_op     = ALUOP_ADD;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures the branch target speculatively
                w_alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_next      = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_next    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req    = 1'b1;
                w_mem_write  = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = bus.mem_ready;
                w_next       = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALUOP_SUB;
                w_branch     = 1'b1;
                w_pc_src     = PCSRC_ALUOUT;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pc_src     = PCSRC_JUMP;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_write  = w_mem_write;
    assign bus.iord       = w_iord;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_en      = w_pc_write | (w_branch & bus.zero);
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.reg_write  = w_reg_write;
    assign bus.instr_done = w_instr_done;
    assign bus.illegal_op = w_illegal_op;
    assign bus.state_dbg  = ST_W'(r_state);

    alu_decoder #(.OP_W(OP_W)) u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct       (bus.funct),
        .o_alu_control (bus.alu_control)
    );
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_write, iord, ir_write, pc_en;
        logic [1:0] pc_src;
        logic       a;
        logic [1:0] b;
        logic [1:0] aluop;
        logic [3:0] alu_ctl;
        logic       reg_dst, mem_to_reg, reg_write, done, ill;
    } obs_t;

    typedef struct {
        int   st;
        logic rdy;
        logic ill;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];
    logic [5:0] legal_ops [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] fn_list   [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.OP_W(6), .ST_W(4)) bus ();

    mips_multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    function automatic logic [3:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b01) return 4'b0110;
        if (aop != 2'b10) return 4'b0010;
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic obs_t model_out(input int s, input logic rdy, input logic z, input logic [5:0] fn);
        obs_t o = '0;
        o.st = 4'(s);
        case (s)
            0:  begin o.mem_req = 1; o.b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
            1:  o.b = 2'b11;
            2:  begin o.a = 1; o.b = 2'b10; end
            3:  begin o.mem_req = 1; o.iord = 1; end
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; o.done = 1; end
            5:  begin o.mem_req = 1; o.mem_write = 1; o.iord = 1; o.done = rdy; end
            6:  begin o.a = 1; o.aluop = 2'b10; end
            7:  begin o.reg_dst = 1; o.reg_write = 1; o.done = 1; end
            8:  begin o.a = 1; o.aluop = 2'b01; o.pc_src = 2'b01; o.pc_en = z; o.done = 1; end
            9:  begin o.a = 1; o.b = 2'b10; end
            10: begin o.reg_write = 1; o.done = 1; end
            11: begin o.pc_src = 2'b10; o.pc_en = 1; o.done = 1; end
            default: o = '0;
        endcase
        o.alu_ctl = ref_alu(o.aluop, fn);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state_dbg;           o.mem_req = bus.mem_req;
        o.mem_write = bus.mem_write;    o.iord = bus.iord;
        o.ir_write = bus.ir_write;      o.pc_en = bus.pc_en;
        o.pc_src = bus.pc_src;          o.a = bus.alu_src_a;
        o.b = bus.alu_src_b;            o.aluop = bus.alu_op;
        o.alu_ctl = bus.alu_control;    o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;  o.reg_write = bus.reg_write;
        o.done = bus.instr_done;        o.ill = bus.illegal_op;
        return o;
    endfunction

    // Drives one instruction from its phase list and records expected/observed per cycle.
    // idle: 0/1 drives that mem_ready level outside memory phases, 2 drives it randomly.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int idle);
        int    body[$];
        step_t plan[$];
        logic  legal;
        exp_q.delete();
        obs_q.delete();
        legal = 1'b1;
        case (op)
            OP_LW:    body = '{1, 2, 3, 4};
            OP_SW:    body = '{1, 2, 5};
            OP_RTYPE: body = '{1, 6, 7};
            OP_BEQ:   body = '{1, 8};
            OP_ADDI:  body = '{1, 9, 10};
            OP_J:     body = '{1, 11};
            default:  begin body = '{1}; legal = 1'b0; end
        endcase
        for (int i = 0; i < fw; i++) plan.push_back('{0, 1'b0, 1'b0});
        plan.push_back('{0, 1'b1, 1'b0});
        foreach (body[i]) begin
            if (body[i] == 3 || body[i] == 5) begin
                for (int w = 0; w < mw; w++) plan.push_back('{body[i], 1'b0, 1'b0});
                plan.push_back('{body[i], 1'b1, 1'b0});
            end else begin
                plan.push_back('{body[i], (idle == 2) ? 1'($urandom_range(0, 1)) : 1'(idle),
                                 (body[i] == 1) && !legal});
            end
        end
        foreach (plan[i]) begin
            obs_t e;
            @(negedge clk);
            reset = 1'b0;
            bus.opcode = op; bus.funct = fn; bus.zero = z; bus.mem_ready = plan[i].rdy;
            #1;
            e = model_out(plan[i].st, plan[i].rdy, z, fn);
            e.ill = plan[i].ill;
            exp_q.push_back(e);
            obs_q.push_back(sample());
        end
    endtask

    task automatic test_reset();
        obs_t o;
        repeat (2) @(posedge clk);
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        o = sample();
        n_checks++;
        if (o !== model_out(0, 1'b0, 1'b0, 6'd0)) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", o, model_out(0, 1'b0, 1'b0, 6'd0));
        end
        bus.mem_ready = 1'b1; #1;
        o = sample();
        n_checks++;
        if (o !== model_out(0, 1'b1, 1'b0, 6'd0)) begin
            n_fail++; $display("FAIL reset_fetch_ready: got %h expected %h", o, model_out(0, 1'b1, 1'b0, 6'd0));
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.state_dbg !== 4'd0) begin
            n_fail++; $display("FAIL reset_overrides: state %0d expected 0", bus.state_dbg);
        end
        bus.mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_memrd();
        obs_t o;
        @(negedge clk); bus.opcode = OP_LW; bus.mem_ready = 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (bus.state_dbg !== 4'd3 || bus.mem_req !== 1'b1 || bus.iord !== 1'b1) begin
            n_fail++; $display("FAIL midrd_reach: state %0d req %b iord %b expected 3 1 1",
                               bus.state_dbg, bus.mem_req, bus.iord);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        o = sample();
        n_checks++;
        if (o !== model_out(0, 1'b0, 1'b0, 6'd0)) begin
            n_fail++; $display("FAIL midrd_reset: got %h expected %h", o, model_out(0, 1'b0, 1'b0, 6'd0));
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        int dones = 0;
        run_instr(OP_RTYPE, 6'b100000, 1'b0, 0, 0, 1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rtype cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            dones += int'(obs_q[i].done);
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL rtype_done_count: got %0d expected 1", dones); end
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        n_checks++;
        if (bus.state_dbg !== 4'd0) begin n_fail++; $display("FAIL rtype_end: state %0d expected 0", bus.state_dbg); end
    endtask

    task automatic test_lw_wait();
        int nreq = 0;
        run_instr(OP_LW, 6'd0, 1'b0, 0, 3, 2);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i].mem_req && obs_q[i].iord) nreq++;
        end
        n_checks++;
        if (nreq != 4) begin n_fail++; $display("FAIL lw_wait_req_cycles: got %0d expected 4", nreq); end
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        n_checks++;
        if (bus.state_dbg !== 4'd0) begin n_fail++; $display("FAIL lw_wait_end: state %0d expected 0", bus.state_dbg); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            run_instr(OP_BEQ, 6'd0, 1'(z), 0, 0, 2);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL beq_z%0d cycle %0d: got %h expected %h", z, i, obs_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (obs_q[2].pc_en !== 1'(z) || obs_q[2].pc_src !== 2'b01) begin
                n_fail++; $display("FAIL beq_z%0d_pc: pc_en %b pc_src %b expected %0d 01",
                                   z, obs_q[2].pc_en, obs_q[2].pc_src, z);
            end
            @(negedge clk); bus.mem_ready = 1'b0; #1;
            n_checks++;
            if (bus.state_dbg !== 4'd0) begin n_fail++; $display("FAIL beq_z%0d_end: state %0d expected 0", z, bus.state_dbg); end
        end
    endtask

    task automatic test_illegal();
        int ills = 0, writes = 0;
        run_instr(6'b111111, 6'd0, 1'b0, 1, 0, 2);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            ills   += int'(obs_q[i].ill);
            writes += int'(obs_q[i].reg_write) + int'(obs_q[i].mem_write);
        end
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        ills   += int'(bus.illegal_op);
        n_checks++;
        if (ills != 1 || writes != 0 || bus.state_dbg !== 4'd0) begin
            n_fail++; $display("FAIL illegal_pulse: pulses %0d writes %0d state %0d expected 1 0 0",
                               ills, writes, bus.state_dbg);
        end
    endtask

    task automatic test_sw();
        int wr = 0, rw = 0, dn = 0;
        run_instr(OP_SW, 6'd0, 1'b0, 0, 0, 1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL sw cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            wr += int'(obs_q[i].mem_write && obs_q[i].mem_req && obs_q[i].iord);
            rw += int'(obs_q[i].reg_write);
            dn += int'(obs_q[i].done);
        end
        n_checks++;
        if (wr != 1 || rw != 0 || dn != 1) begin
            n_fail++; $display("FAIL sw_counts: write %0d regwr %0d done %0d expected 1 0 1", wr, rw, dn);
        end
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        n_checks++;
        if (bus.state_dbg !== 4'd0) begin n_fail++; $display("FAIL sw_end: state %0d expected 0", bus.state_dbg); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            int k = $urandom_range(0, 7);
            op = (k < 6) ? legal_ops[k] : 6'($urandom_range(0, 63));
            run_instr(op, fn_list[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3), 2);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL b2b instr %0d op %b cycle %0d: got %h expected %h",
                                       n, op, i, obs_q[i], exp_q[i]);
                end
            end
            @(negedge clk); bus.mem_ready = 1'b0; #1;
            n_checks++;
            if (bus.state_dbg !== 4'd0) begin
                n_fail++; $display("FAIL b2b_end instr %0d: state %0d expected 0", n, bus.state_dbg);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_reset_mid_memrd();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_sw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles through a single shared ALU and a unified instruction/data memory port.
- Drives alu_op into the existing AluDecoder (instantiated inside), plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake.

Parameters:
- OP_W, 6, opcode and funct field width.
- ST_W, 4, state register width (exported on debug port).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write strobe (valid with mem_req).
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction register load.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-defined.
- alu_control  out  4  AluDecoder output, passed through.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.
- state_dbg  out  ST_W  current state encoding.

Behaviour:
- Reset: synchronous. reset high at a rising edge forces state = FETCH; it overrides every other transition, including mid-instruction and mid-memory-wait.
- Outputs are a pure decode of state (plus mem_ready / zero where noted). Every output not listed for a state is 0.
- Post-reset output values (FETCH):
  - mem_req = 1; iord = 0; alu_src_a = 0; alu_src_b = 01; alu_op = 00; pc_src = 00.
  - ir_write = mem_ready; pc_write = mem_ready.
- States, encoding 0..11, with outputs and transitions:
  - FETCH: outputs as above. Stays while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXEC.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JUMP.
    - any other opcode → FETCH with illegal_op = 1 for that cycle.
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw → MEMRD; sw → MEMWR.
  - MEMRD: mem_req = 1, iord = 1. Holds until mem_ready, then → MEMWB.
  - MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1, instr_done = 1. → FETCH.
  - MEMWR: mem_req = 1, mem_write = 1, iord = 1. Holds until mem_ready. On mem_ready: instr_done = 1, → FETCH.
  - EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. → ALUWB.
  - ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1, instr_done = 1. → FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, branch = 1, pc_src = 01, instr_done = 1. → FETCH.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. → ADDIWB.
  - ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1, instr_done = 1. → FETCH.
  - JUMP: pc_src = 10, pc_write = 1, instr_done = 1. → FETCH.
- Handshake rules:
  - mem_req holds high, with iord, mem_write and address selects stable, every wait cycle until mem_ready.
  - mem_ready sampled outside FETCH/MEMRD/MEMWR is ignored.
- Latencies with zero wait states:
  - lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
  - Each wait cycle adds 1.
- pc_en is combinational:
  - In BRANCH, pc_en = zero.
  - In FETCH, pc_en = mem_ready.
  - In JUMP, pc_en = 1.
  - Elsewhere pc_en = 0.
- Illegal-state recovery: any unused encoding (12..15) → FETCH next cycle.
- funct is consumed only by AluDecoder; the FSM ignores it.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum (ST_W wide);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - alu_op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - alu_src_b and pc_src select constants.
- One sub-module: the existing AluDecoder, fed alu_op and funct, driving alu_control.

Test Plan:
- Reset mid-MEMRD (state 3, mem_ready = 0) → next edge state_dbg = 0 (FETCH), mem_req = 1, iord = 0, reg_write = 0.
- R-type ADD (opcode 000000, funct 100000), mem_ready = 1 throughout:
  - states 0, 1, 6, 7, 0;
  - alu_op = 10 in EXEC;
  - reg_write = 1, reg_dst = 1 only in ALUWB;
  - instr_done pulses once; 4 cycles total.
- lw with mem_ready held 0 for 3 cycles in MEMRD:
  - mem_req and iord stay 1 for 4 cycles;
  - MEMWB asserts mem_to_reg = 1, reg_write = 1;
  - total 8 cycles.
- beq with zero = 1 → pc_en = 1, pc_src = 01 in BRANCH. Repeat with zero = 0 → pc_en = 0; both return to FETCH after 3 cycles.
- Opcode 111111 in DECODE → illegal_op = 1 for exactly one cycle, next state FETCH, no reg_write or mem_write asserted.
- sw with mem_ready = 1 → MEMWR has mem_write = 1, mem_req = 1, iord = 1 for exactly one cycle, instr_done = 1, reg_write never asserted.
